// File: rtl/modexp_xor_enc.sv
// Serial Diffie-Hellman key/cipher engine: k = base^exp mod p (MSB-first
// square-and-multiply, bit-serial restoring reduction), then c = k ^ msg.
module modexp_xor_enc #(
  parameter int W     = 8,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     base,
  input  logic [EXP_W-1:0] exp,
  input  logic [W-1:0]     p,
  input  logic [W-1:0]     msg,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [W-1:0]     k_o,
  output logic [W-1:0]     c_o
);

  localparam int CNT_W = $clog2(2 * W);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {IDLE, INIT, MUL, RED, OUT} state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       base_r, p_r, msg_r, acc, rem;
  logic [EXP_W-1:0]   exp_r;
  logic [2*W-1:0]     prod;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               is_mult;

  logic [W:0]         shifted, rem_nxt;
  logic               red_last, take_mult, last_bit;

  // Remainder stays below p, so one shifted-in bit fits in W+1 bits and a
  // single conditional subtract restores it below p again.
  always_comb begin
    shifted   = {rem, prod[2*W-1]};
    rem_nxt   = (shifted >= {1'b0, p_r}) ? shifted - {1'b0, p_r} : shifted;
    red_last  = (cnt == CNT_W'(2 * W - 1));
    take_mult = !is_mult && exp_r[idx];
    last_bit  = (idx == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = INIT;
      INIT: state_nxt = (p_r == '0) ? OUT : MUL;
      MUL:  state_nxt = RED;
      RED: begin
        if (red_last) begin
          if (take_mult)     state_nxt = MUL;
          else if (last_bit) state_nxt = OUT;
          else               state_nxt = MUL;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == OUT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r  <= '0;
      p_r     <= '0;
      msg_r   <= '0;
      exp_r   <= '0;
      acc     <= '0;
      rem     <= '0;
      prod    <= '0;
      cnt     <= '0;
      idx     <= '0;
      is_mult <= 1'b0;
      err     <= 1'b0;
      k_o     <= '0;
      c_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            p_r    <= p;
            msg_r  <= msg;
            k_o    <= '0;
            c_o    <= '0;
            err    <= 1'b0;
          end
        end
        INIT: begin
          if (p_r == '0) begin
            err <= 1'b1;
          end else begin
            acc     <= (p_r == W'(1)) ? '0 : W'(1);
            idx     <= IDX_W'(EXP_W - 1);
            is_mult <= 1'b0;
          end
        end
        MUL: begin
          prod <= is_mult ? {{W{1'b0}}, acc} * {{W{1'b0}}, base_r}
                          : {{W{1'b0}}, acc} * {{W{1'b0}}, acc};
          rem  <= '0;
          cnt  <= '0;
        end
        RED: begin
          prod <= prod << 1;
          rem  <= rem_nxt[W-1:0];
          cnt  <= cnt + CNT_W'(1);
          if (red_last) begin
            acc <= rem_nxt[W-1:0];
            if (take_mult) begin
              is_mult <= 1'b1;
            end else begin
              is_mult <= 1'b0;
              if (last_bit) begin
                k_o <= rem_nxt[W-1:0];
                c_o <= rem_nxt[W-1:0] ^ msg_r;
              end else begin
                idx <= idx - IDX_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_xor_enc.sv
// Scoreboard bench for modexp_xor_enc: the driver queues expected results with
// their done cycle; a negedge monitor pops and compares on every done pulse.
module tb_modexp_xor_enc;
  localparam int W     = 8;
  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     base = '0, p = '0, msg = '0;
  logic [EXP_W-1:0] exp = '0;
  logic             busy, done, err;
  logic [W-1:0]     k_o, c_o;

  modexp_xor_enc #(.W(W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .p(p),
    .msg(msg), .busy(busy), .done(done), .err(err), .k_o(k_o), .c_o(c_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] k;
    logic [W-1:0] c;
    logic         e;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_k"},   32'(k_o), 32'(mon_e.k));
        chk({mon_e.name, "_c"},   32'(c_o), 32'(mon_e.c));
        chk({mon_e.name, "_err"}, 32'(err), 32'(mon_e.e));
        chk({mon_e.name, "_lat"}, 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Returns on the negedge following the accept edge; cyc then names that edge.
  task automatic issue(input logic [W-1:0] b, input logic [EXP_W-1:0] x,
                       input logic [W-1:0] pp, input logic [W-1:0] m,
                       input logic [W-1:0] k, input logic [W-1:0] c,
                       input logic e, input int lat, input string name);
    exp_t ent;
    @(negedge clk);
    base = b; exp = x; p = pp; msg = m; start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    ent.k = k; ent.c = c; ent.e = e; ent.due = cyc + lat - 1; ent.name = name;
    sb.push_back(ent);
    @(negedge clk);
    start = 1'b0;
    base = '1; exp = '1; p = '1; msg = '1;
    chk({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
      sb.delete();
    end
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_k",    32'(k_o),  32'd0);
    chk("rst_c",    32'(c_o),  32'd0);
    rst = 1'b0;

    // 5^3 mod 23 = 10; N = 8 + 2 = 10 -> 172
    issue(8'd5, 8'd3, 8'd23, 8'h5A, 8'h0A, 8'h50, 1'b0, 172, "t1");
    wait_idle(400, "t1");
    // 30 mod 23 = 7; N = 9 -> 155
    issue(8'd30, 8'd1, 8'd23, 8'h00, 8'd7, 8'd7, 1'b0, 155, "t2");
    wait_idle(400, "t2");
    // exp = 0 -> 1; N = 8 -> 138
    issue(8'd7, 8'd0, 8'd23, 8'h33, 8'd1, 8'h32, 1'b0, 138, "t3a");
    wait_idle(400, "t3a");
    // p = 1 -> 0; N = 16 -> 274
    issue(8'd9, 8'hFF, 8'd1, 8'h3C, 8'd0, 8'h3C, 1'b0, 274, "t3b");
    wait_idle(600, "t3b");

    issue(8'h12, 8'd5, 8'd0, 8'hFF, 8'd0, 8'd0, 1'b1, 2, "t4");
    wait_idle(20, "t4");
    repeat (3) @(negedge clk);
    chk("t4_err_hold", 32'(err), 32'd1);
    chk("t4_k_hold",   32'(k_o), 32'd0);
    // 2^4 mod 23 = 16; N = 9 -> 155
    issue(8'd2, 8'd4, 8'd23, 8'h01, 8'd16, 8'h11, 1'b0, 155, "t4b");
    chk("t4b_err_clr", 32'(err), 32'd0);
    wait_idle(400, "t4b");

    issue(8'd5, 8'd3, 8'd23, 8'h5A, 8'h0A, 8'h50, 1'b0, 172, "t5");
    a = acc_cyc;
    wait_until(a + 4);
    base = 8'd1; exp = 8'd1; p = 8'd7; msg = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(a + 171);
    base = 8'd1; exp = 8'd1; p = 8'd7; msg = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400, "t5");
    repeat (20) @(negedge clk);
    chk("t5_k_hold", 32'(k_o), 32'h0A);
    chk("t5_c_hold", 32'(c_o), 32'h50);
    chk("t5_busy",   32'(busy), 32'd0);

    issue(8'd5, 8'd3, 8'd23, 8'h5A, 8'h0A, 8'h50, 1'b0, 172, "t6");
    a = acc_cyc;
    wait_until(a + 49);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err",  32'(err),  32'd0);
    chk("t6_k",    32'(k_o),  32'd0);
    chk("t6_c",    32'(c_o),  32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_no_done_busy", 32'(busy), 32'd0);
    issue(8'd5, 8'd3, 8'd23, 8'h5A, 8'h0A, 8'h50, 1'b0, 172, "t6b");
    wait_idle(400, "t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
